// File: rtl/nbit_demux_deser.sv
// Bit-serial to parallel demultiplexer: steers each accepted bit to word[demux_s] and
// presents the completed word on a valid/ready port. Optional parity via NBIT_DEMUX_PARITY_EN.
module nbit_demux_deser #(
  parameter int unsigned DATA_SIZE = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    demux_d,
  input  logic [DATA_SIZE-1:0]    demux_s,
  input  logic                    demux_last,
  input  logic                    demux_valid,
  output logic                    demux_ready,
  output logic [2**DATA_SIZE-1:0] word_q,
  output logic                    word_valid,
  input  logic                    word_ready
`ifdef NBIT_DEMUX_PARITY_EN
  ,
  output logic                    word_parity
`endif
);

  localparam int unsigned W     = 2**DATA_SIZE;
  localparam int unsigned CNT_W = DATA_SIZE + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     word_d;

`ifdef NBIT_DEMUX_PARITY_EN
  logic parity_q, parity_d;
  assign word_parity = parity_q;
`endif

  // Handshake outputs depend on the state register only; rst just masks acceptance.
  assign demux_ready = (state_q == FILL) && !rst;
  assign word_valid  = (state_q == HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
`ifdef NBIT_DEMUX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      FILL: begin
        if (demux_valid) begin
          word_d[demux_s] = demux_d;
          cnt_d           = cnt_q + 1'b1;
          if (demux_last || (cnt_q == CNT_LAST)) begin
            state_d = HOLD;
`ifdef NBIT_DEMUX_PARITY_EN
            parity_d = ^word_d;
`endif
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_d = FILL;
          cnt_d   = '0;
          word_d  = '0;
`ifdef NBIT_DEMUX_PARITY_EN
          parity_d = 1'b0;
`endif
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef NBIT_DEMUX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
`ifdef NBIT_DEMUX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_nbit_demux_deser.sv
// Directed bench for nbit_demux_deser (DATA_SIZE=6); parity checks active with NBIT_DEMUX_PARITY_EN.
module tb_nbit_demux_deser;

  logic        clk;
  logic        rst;
  logic        demux_d;
  logic [5:0]  demux_s;
  logic        demux_last;
  logic        demux_valid;
  logic        demux_ready;
  logic [63:0] word_q;
  logic        word_valid;
  logic        word_ready;
`ifdef NBIT_DEMUX_PARITY_EN
  logic        word_parity;
`endif

  int checks   = 0;
  int failures = 0;

  nbit_demux_deser #(.DATA_SIZE(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .demux_d     (demux_d),
    .demux_s     (demux_s),
    .demux_last  (demux_last),
    .demux_valid (demux_valid),
    .demux_ready (demux_ready),
    .word_q      (word_q),
    .word_valid  (word_valid),
    .word_ready  (word_ready)
`ifdef NBIT_DEMUX_PARITY_EN
    ,
    .word_parity (word_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [5:0] s, input logic d, input logic last);
    demux_valid = 1'b1;
    demux_s     = s;
    demux_d     = d;
    demux_last  = last;
    tick();
    demux_valid = 1'b0;
    demux_last  = 1'b0;
  endtask

  task automatic handshake();
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; demux_d = 1'b0; demux_s = '0; demux_last = 1'b0;
    demux_valid = 1'b0; word_ready = 1'b0;
    tick(); tick();
    chk("rst_word_q", word_q, 64'h0);
    chk("rst_word_valid", {63'h0, word_valid}, 64'h0);
    chk("rst_demux_ready", {63'h0, demux_ready}, 64'h0);
    rst = 1'b0;
    #1;
    chk("fill_ready_after_rst", {63'h0, demux_ready}, 64'h1);

    // 1: 64 beats s=i, d=i[0], no last
    for (int i = 0; i < 63; i++) beat(6'(i), i[0], 1'b0);
    chk("t1_not_valid_63", {63'h0, word_valid}, 64'h0);
    beat(6'd63, 1'b1, 1'b0);
    chk("t1_valid", {63'h0, word_valid}, 64'h1);
    chk("t1_word", word_q, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t1_ready_low", {63'h0, demux_ready}, 64'h0);
`ifdef NBIT_DEMUX_PARITY_EN
    chk("t1_parity", {63'h0, word_parity}, 64'h0);
`endif

    // 3: backpressure in HOLD with beats offered
    for (int i = 0; i < 10; i++) beat(6'd0, 1'b1, 1'b0);
    chk("t3_word_frozen", word_q, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("t3_ready_low", {63'h0, demux_ready}, 64'h0);
    chk("t3_still_valid", {63'h0, word_valid}, 64'h1);
    handshake();
    chk("t3_fill_valid", {63'h0, word_valid}, 64'h0);
    chk("t3_fill_word", word_q, 64'h0);
    chk("t3_fill_ready", {63'h0, demux_ready}, 64'h1);

    // 2: early last
    beat(6'd5, 1'b1, 1'b0);
    chk("t2_not_valid", {63'h0, word_valid}, 64'h0);
    beat(6'd63, 1'b1, 1'b1);
    chk("t2_valid", {63'h0, word_valid}, 64'h1);
    chk("t2_word", word_q, 64'h8000_0000_0000_0020);
    tick(); tick();
    chk("t2_held", word_q, 64'h8000_0000_0000_0020);
    handshake();

    // next word count restarts at 0; last together with 64th beat
    for (int i = 0; i < 63; i++) beat(6'(i), 1'b1, 1'b0);
    chk("t2b_not_valid_63", {63'h0, word_valid}, 64'h0);
    beat(6'd63, 1'b1, 1'b1);
    chk("t2b_valid", {63'h0, word_valid}, 64'h1);
    chk("t2b_word", word_q, 64'hFFFF_FFFF_FFFF_FFFF);
    handshake();
    chk("t2b_single_completion", {63'h0, word_valid}, 64'h0);

    // 4: duplicate index, last write wins
    beat(6'd3, 1'b1, 1'b0);
    beat(6'd3, 1'b0, 1'b1);
    chk("t4_valid", {63'h0, word_valid}, 64'h1);
    chk("t4_word", word_q, 64'h0);
    handshake();

    // word_ready while not valid is ignored; then 5: rst mid-word
    word_ready = 1'b1;
    beat(6'd7, 1'b1, 1'b0);
    word_ready = 1'b0;
    chk("ready_no_effect_valid", {63'h0, word_valid}, 64'h0);
    chk("ready_no_effect_word", word_q, 64'h80);
    for (int i = 8; i < 17; i++) beat(6'(i), 1'b1, 1'b0);
    chk("t5_partial", word_q, 64'h0000_0000_0001_FF80);
    rst = 1'b1;
    tick();
    chk("t5_rst_word", word_q, 64'h0);
    chk("t5_rst_valid", {63'h0, word_valid}, 64'h0);
    chk("t5_rst_ready", {63'h0, demux_ready}, 64'h0);
    rst = 1'b0;
    beat(6'd2, 1'b1, 1'b1);
    chk("t5_clean_word", word_q, 64'h4);
    chk("t5_clean_valid", {63'h0, word_valid}, 64'h1);
    handshake();

    // 6: parity
    beat(6'd0, 1'b1, 1'b0);
    beat(6'd5, 1'b1, 1'b1);
    chk("t6_word21", word_q, 64'h21);
`ifdef NBIT_DEMUX_PARITY_EN
    chk("t6_parity21", {63'h0, word_parity}, 64'h0);
`endif
    handshake();
    beat(6'd0, 1'b1, 1'b1);
    chk("t6_word01", word_q, 64'h1);
`ifdef NBIT_DEMUX_PARITY_EN
    chk("t6_parity01", {63'h0, word_parity}, 64'h1);
`endif
    handshake();
    chk("t6_after_word", word_q, 64'h0);
`ifdef NBIT_DEMUX_PARITY_EN
    chk("t6_parity_cleared", {63'h0, word_parity}, 64'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
